// File: rtl/cmd_loader_pkg.sv
// Shared types and helpers for the command-loader execute path.
// Holds the injector state encoding, the JP opcode and the Z80 read-start predicate.
package cmd_loader_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWaitDl = 3'd1,
        StArmed  = 3'd2,
        StOp     = 3'd3,
        StLo     = 3'd4,
        StHi     = 3'd5
    } inj_state_e;

    localparam logic [7:0] OPC_JP = 8'hC3;

    // A memory read starts on the first clock where RD falls with MREQ low.
    function automatic logic rd_start_f(input logic prev_rd_n, input logic rd_n,
                                        input logic mreq_n);
        return prev_rd_n & ~rd_n & ~mreq_n;
    endfunction

endpackage

// File: rtl/cmd_exec_injector_if.sv
// Z80-side bus bundle seen by the execute injector.
// The master drives CPU control and RAM data; the slave returns CPU data-in and WAIT.
interface cmd_exec_injector_if #(
    parameter int unsigned DATA = 8
);
    logic            cpu_m1_n;
    logic            cpu_mreq_n;
    logic            cpu_iorq_n;
    logic            cpu_rd_n;
    logic [DATA-1:0] ram_dout;
    logic [DATA-1:0] cpu_din;
    logic            cpu_wait_n;

    modport master (
        output cpu_m1_n, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, ram_dout,
        input  cpu_din, cpu_wait_n
    );

    modport slave (
        input  cpu_m1_n, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, ram_dout,
        output cpu_din, cpu_wait_n
    );
endinterface

// File: rtl/z80_bus_cycle_detect.sv
// Z80 bus snooper: flags the start of a memory read, whether it is an opcode fetch,
// and the end of a memory read, each as a one-clock pulse.
module z80_bus_cycle_detect
    import cmd_loader_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic m1_n,
    input  logic mreq_n,
    input  logic iorq_n,
    input  logic rd_n,
    output logic rd_start,
    output logic is_fetch,
    output logic rd_end
);

    logic prev_rd_n;
    logic prev_mreq_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_rd_n   <= 1'b1;
            prev_mreq_n <= 1'b1;
        end else begin
            prev_rd_n   <= rd_n;
            prev_mreq_n <= mreq_n;
        end
    end

    assign rd_start = rd_start_f(prev_rd_n, rd_n, mreq_n);
    // Interrupt acknowledge never has MREQ low, so iorq_n only guards against odd bus states.
    assign is_fetch = rd_start & ~m1_n & iorq_n;
    assign rd_end   = ~prev_rd_n & rd_n & ~prev_mreq_n;

endmodule

// File: rtl/cmd_exec_injector.sv
// Redirects the Z80 to a loader-supplied address by substituting JP nn into the next
// opcode fetch after a download, and holds the CPU in WAIT while the download runs.
module cmd_exec_injector
    import cmd_loader_pkg::*;
#(
    parameter int unsigned ADDR  = 16,
    parameter int unsigned DATA  = 8,
    parameter int unsigned TMO_W = 24
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 execute_enable,
    input  logic [ADDR-1:0]      execute_addr,
    input  logic                 loader_download,
    cmd_exec_injector_if.slave   bus,
    output logic                 inject_busy,
    output logic                 inject_timeout
);

    inj_state_e       state_q, state_d;
    logic             sel_q, sel_d;
    logic [DATA-1:0]  data_q, data_d;
    logic [ADDR-1:0]  target_q, target_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             timeout_q, timeout_d;
    logic             wait_n_q;

    logic rd_start;
    logic is_fetch;
    logic rd_end;

    z80_bus_cycle_detect u_detect (
        .clock    (clock),
        .reset    (reset),
        .m1_n     (bus.cpu_m1_n),
        .mreq_n   (bus.cpu_mreq_n),
        .iorq_n   (bus.cpu_iorq_n),
        .rd_n     (bus.cpu_rd_n),
        .rd_start (rd_start),
        .is_fetch (is_fetch),
        .rd_end   (rd_end)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        data_d    = data_q;
        target_d  = target_q;
        tmo_d     = tmo_q;
        timeout_d = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (execute_enable) begin
                    target_d  = execute_addr;
                    timeout_d = 1'b0;
                    tmo_d     = '0;
                    state_d   = StWaitDl;
                end
            end
            StWaitDl: begin
                if (!loader_download) state_d = StArmed;
            end
            StArmed: begin
                if (tmo_q != '1) tmo_d = tmo_q + TMO_W'(1);
                if (is_fetch) begin
                    data_d  = DATA'(OPC_JP);
                    sel_d   = 1'b1;
                    state_d = StOp;
                end else if (tmo_q == '1) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            StOp, StLo: begin
                if (rd_end) sel_d = 1'b0;
                // A fresh fetch before the operand read means the sequence broke: restart it.
                if (is_fetch) begin
                    data_d  = DATA'(OPC_JP);
                    sel_d   = 1'b1;
                    state_d = StOp;
                end else if (rd_start) begin
                    sel_d = 1'b1;
                    if (state_q == StOp) begin
                        data_d  = target_q[DATA-1:0];
                        state_d = StLo;
                    end else begin
                        data_d  = target_q[2*DATA-1:DATA];
                        state_d = StHi;
                    end
                end
            end
            StHi: begin
                if (rd_end) begin
                    sel_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            sel_q     <= 1'b0;
            data_q    <= '0;
            target_q  <= '0;
            tmo_q     <= '0;
            timeout_q <= 1'b0;
            wait_n_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            data_q    <= data_d;
            target_q  <= target_d;
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
            wait_n_q  <= ~loader_download;
        end
    end

    assign bus.cpu_din     = sel_q ? data_q : bus.ram_dout;
    assign bus.cpu_wait_n  = wait_n_q;
    assign inject_busy     = (state_q != StIdle);
    assign inject_timeout  = timeout_q;

endmodule

// File: tb/tb_cmd_exec_injector.sv
// Directed bench for cmd_exec_injector: Z80-style reads with a scoreboard of expected data.
module tb_cmd_exec_injector;

    logic        clock;
    logic        reset;
    logic        execute_enable;
    logic [15:0] execute_addr;
    logic        loader_download;
    logic        inject_busy;
    logic        inject_timeout;

    int vectors;
    int miscompares;
    logic [7:0] exp_q[$];

    cmd_exec_injector_if #(.DATA(8)) bus ();

    cmd_exec_injector #(
        .ADDR  (16),
        .DATA  (8),
        .TMO_W (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .execute_enable  (execute_enable),
        .execute_addr    (execute_addr),
        .loader_download (loader_download),
        .bus             (bus),
        .inject_busy     (inject_busy),
        .inject_timeout  (inject_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic arm(input logic [15:0] addr);
        @(negedge clock);
        execute_enable = 1'b1;
        execute_addr   = addr;
        @(negedge clock);
        execute_enable = 1'b0;
        execute_addr   = 16'hDEAD;
    endtask

    task automatic start_read(input logic fetch, input logic [7:0] ram);
        @(negedge clock);
        bus.ram_dout   = ram;
        bus.cpu_m1_n   = ~fetch;
        bus.cpu_mreq_n = 1'b0;
        bus.cpu_rd_n   = 1'b0;
    endtask

    task automatic sample_read(input string tag);
        repeat (2) @(negedge clock);
        if (exp_q.size() == 0) check({tag, "_sb_empty"}, 16'h0, 16'h1);
        else check(tag, {8'h00, bus.cpu_din}, {8'h00, exp_q.pop_front()});
    endtask

    task automatic end_read();
        @(negedge clock);
        bus.cpu_m1_n   = 1'b1;
        bus.cpu_mreq_n = 1'b1;
        bus.cpu_rd_n   = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic cpu_read(input string tag, input logic fetch, input logic [7:0] ram,
                            input logic [7:0] exp);
        exp_q.push_back(exp);
        start_read(fetch, ram);
        sample_read(tag);
        end_read();
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        reset           = 1'b1;
        execute_enable  = 1'b0;
        execute_addr    = 16'h0000;
        loader_download = 1'b0;
        bus.cpu_m1_n    = 1'b1;
        bus.cpu_mreq_n  = 1'b1;
        bus.cpu_iorq_n  = 1'b1;
        bus.cpu_rd_n    = 1'b1;
        bus.ram_dout    = 8'hA5;

        repeat (3) @(negedge clock);
        check("rst_wait_n", {15'h0, bus.cpu_wait_n}, 16'h1);
        check("rst_busy", {15'h0, inject_busy}, 16'h0);
        check("rst_timeout", {15'h0, inject_timeout}, 16'h0);
        check("rst_din", {8'h00, bus.cpu_din}, 16'h00A5);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Basic jump; a second request while busy must be ignored.
        arm(16'h5A3C);
        check("t1_busy", {15'h0, inject_busy}, 16'h1);
        arm(16'h1111);
        cpu_read("t1_op", 1'b1, 8'h11, 8'hC3);
        cpu_read("t1_lo", 1'b0, 8'h22, 8'h3C);
        cpu_read("t1_hi", 1'b0, 8'h33, 8'h5A);
        check("t1_busy_done", {15'h0, inject_busy}, 16'h0);
        cpu_read("t1_after", 1'b1, 8'h44, 8'h44);

        // Request during download: deferred, CPU held in WAIT meanwhile.
        @(negedge clock);
        loader_download = 1'b1;
        @(negedge clock);
        check("t2_wait_low", {15'h0, bus.cpu_wait_n}, 16'h0);
        arm(16'hFFE1);
        cpu_read("t2_dl_fetch", 1'b1, 8'h55, 8'h55);
        check("t2_wait_still_low", {15'h0, bus.cpu_wait_n}, 16'h0);
        loader_download = 1'b0;
        repeat (2) @(negedge clock);
        check("t2_wait_high", {15'h0, bus.cpu_wait_n}, 16'h1);
        cpu_read("t2_op", 1'b1, 8'h66, 8'hC3);
        cpu_read("t2_lo", 1'b0, 8'h77, 8'hE1);
        cpu_read("t2_hi", 1'b0, 8'h88, 8'hFF);

        // Arm timeout with an idle bus.
        arm(16'h1234);
        repeat (8) @(negedge clock);
        check("t3_no_early_tmo", {15'h0, inject_timeout}, 16'h0);
        for (int i = 0; i < 40 && !inject_timeout; i++) @(negedge clock);
        check("t3_timeout", {15'h0, inject_timeout}, 16'h1);
        check("t3_idle", {15'h0, inject_busy}, 16'h0);
        cpu_read("t3_after", 1'b1, 8'h99, 8'h99);
        check("t3_sticky", {15'h0, inject_timeout}, 16'h1);

        // Re-arm clears the flag; interrupt ack must not trigger; target 0000.
        arm(16'h0000);
        check("t4_tmo_clear", {15'h0, inject_timeout}, 16'h0);
        @(negedge clock);
        bus.ram_dout   = 8'hFF;
        bus.cpu_m1_n   = 1'b0;
        bus.cpu_iorq_n = 1'b0;
        repeat (2) @(negedge clock);
        check("t4_intack_din", {8'h00, bus.cpu_din}, 16'h00FF);
        @(negedge clock);
        bus.cpu_m1_n   = 1'b1;
        bus.cpu_iorq_n = 1'b1;
        cpu_read("t4_op", 1'b1, 8'hAA, 8'hC3);
        cpu_read("t4_lo", 1'b0, 8'hBB, 8'h00);
        cpu_read("t4_hi", 1'b0, 8'hCC, 8'h00);

        // Broken sequence: second fetch restarts at the opcode.
        arm(16'hBEEF);
        cpu_read("t5_op1", 1'b1, 8'h01, 8'hC3);
        cpu_read("t5_op2", 1'b1, 8'h02, 8'hC3);
        cpu_read("t5_lo", 1'b0, 8'h03, 8'hEF);
        cpu_read("t5_hi", 1'b0, 8'h04, 8'hBE);
        check("t5_busy_done", {15'h0, inject_busy}, 16'h0);

        // Reset while the low operand is being driven.
        arm(16'h8421);
        cpu_read("t6_op", 1'b1, 8'h05, 8'hC3);
        exp_q.push_back(8'h21);
        start_read(1'b0, 8'h99);
        sample_read("t6_lo");
        loader_download = 1'b1;
        @(negedge clock);
        check("t6_wait_low", {15'h0, bus.cpu_wait_n}, 16'h0);
        reset = 1'b1;
        #1;
        check("t6_rst_din", {8'h00, bus.cpu_din}, 16'h0099);
        check("t6_rst_busy", {15'h0, inject_busy}, 16'h0);
        check("t6_rst_wait_n", {15'h0, bus.cpu_wait_n}, 16'h1);
        @(negedge clock);
        reset           = 1'b0;
        loader_download = 1'b0;
        end_read();
        cpu_read("t6_after", 1'b1, 8'h5C, 8'h5C);

        check("sb_drained", exp_q.size() == 0 ? 16'h1 : 16'h0, 16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cmd_exec_injector.md
Name: cmd_exec_injector

Overview:
- Sits downstream of the command loader and between main RAM and the Z80 data-in bus.
- Consumes the loader's execute request (start address plus one-cycle enable) and redirects the running CPU to that address. It does this by substituting a JP nn instruction (C3, lo, hi) into the next opcode fetch after the download completes.
- Also holds the CPU in WAIT while a download is active.

Parameters:
- ADDR, 16, CPU address width; execute_addr width
- DATA, 8, CPU data width
- TMO_W, 24, width of arm-timeout counter; timeout fires when the counter saturates at all-ones

Ports:
- clock  in  1  system clock (CPU bus signals are synchronous to it)
- reset  in  1  asynchronous, active-high reset
- execute_enable  in  1  loader request pulse, one or more cycles high
- execute_addr  in  ADDR  jump target; valid while execute_enable is high
- loader_download  in  1  loader busy
- cpu_m1_n  in  1  Z80 M1
- cpu_mreq_n  in  1  Z80 MREQ
- cpu_iorq_n  in  1  Z80 IORQ
- cpu_rd_n  in  1  Z80 RD
- ram_dout  in  DATA  RAM read data
- cpu_din  out  DATA  data presented to the CPU
- cpu_wait_n  out  1  Z80 WAIT
- inject_busy  out  1  high from arm until jump completes or is abandoned
- inject_timeout  out  1  sticky timeout flag; cleared by the next arm

Behaviour:
- Reset values:
  - state=IDLE, inject_sel=0, inject_data=0, target=0.
  - cpu_wait_n=1, inject_busy=0, inject_timeout=0, tmo counter=0.
- Reset applies mid-injection too; the CPU simply sees RAM data from then on.
- cpu_wait_n: registered; equals ~loader_download delayed one clock.
- cpu_din: combinational, inject_sel ? inject_data : ram_dout.
- Read-start detect:
  - Register rd_n and mreq_n.
  - rd_start = prev_rd_n & ~cpu_rd_n & ~cpu_mreq_n.
  - A cycle is a fetch when cpu_m1_n=0 at rd_start.
  - Interrupt-ack cycles (m1_n=0 with iorq_n=0) produce no rd_start with mreq low, so they are ignored.
- Read-end: cpu_rd_n=1 sampled while inject_sel=1. It clears inject_sel on the next clock.
- States:
  - IDLE: on execute_enable=1, latch target<=execute_addr, clear inject_timeout and tmo, then go to WAIT_DL. Hold inject_busy=1 in every state except IDLE.
  - WAIT_DL: stay while loader_download=1. When it is low, go to ARMED.
  - ARMED: count tmo each clock. On a fetch rd_start: inject_data<=8'hC3, inject_sel<=1, go to OP. If tmo saturates first: inject_timeout<=1, go to IDLE.
  - OP: on read-end, drop inject_sel. On the next rd_start with m1_n=1: inject_data<=target[7:0], inject_sel<=1, go to LO.
  - LO: same as OP, but inject target[15:8] and go to HI.
  - HI: on read-end, drop inject_sel and go to IDLE.
- Latency: inject_sel asserts the clock after rd_start. The Z80 samples data at the end of T2/T3, which is several clocks later at the core's clock ratio.
- Sequence break: in OP or LO, a fetch rd_start (m1_n=0) before the operand read restarts at C3 in OP. This covers an aborted or interrupted sequence.
- execute_enable re-asserted while not IDLE: ignored. The first target wins.
- execute_enable while loader_download=1: normal; injection is deferred until download ends.
- execute_enable asserted and download ending in the same clock: IDLE goes to WAIT_DL, then to ARMED on the next clock.
- Target arithmetic: 16-bit, no adjustment; target 0000 injects C3 00 00.

Decomposition:
- Shared package cmd_loader_pkg holds:
  - the state typedef (IDLE, WAIT_DL, ARMED, OP, LO, HI);
  - localparam OPC_JP=8'hC3;
  - the bus-cycle detect helper function.
- One natural sub-module, z80_bus_cycle_detect: registers rd_n/mreq_n and outputs rd_start, is_fetch and rd_end pulses. It is reusable by other bus snoopers.

Test Plan:
- execute_enable pulse with execute_addr=16'h5A3C, download already low; drive a fetch then two memory reads. cpu_din must read C3, 3C, 5A; inject_busy must drop after the third read ends; cpu_din must then follow ram_dout.
- Execute request during loader_download=1 (addr 16'hFFE1). Fetches during the download must return ram_dout and cpu_wait_n must stay 0. After download falls, the first fetch must return C3, then E1, FF.
- Arm with no CPU activity for 2^TMO_W clocks (TMO_W=4 in test). inject_timeout must go to 1 and state to IDLE. A following fetch must return ram_dout; a new execute_enable must clear inject_timeout.
- Interrupt-ack cycle (m1_n=0, iorq_n=0, mreq_n=1) while ARMED. No injection; the following real fetch must receive C3.
- After C3, a second fetch occurs before the operand read. It must get C3 again, followed by lo and hi of the target.
- Assert reset while inject_sel=1 in LO. cpu_din must immediately equal ram_dout, inject_busy=0 and cpu_wait_n=1.
